credit_table_ram: RTL and testbench
===================================

// Module: credit_table_ram
// PURPOSE
//  Parametrised per-connection credit table for the ATM policer: {final_up_limit, available_credit} per VC.
//  Registered policer read, policer write, and host config write port, all arbitrated onto one write port.
//  Same-cycle write-to-read forwarding; hardware init sweep replaces file preload; out-of-range address guard.
//  Sits between the policer datapath and the host/config interface.
// PARAMETERS
//  FINAL_UP_LIMIT_WIDTH    15      width of final_up_limit field (upper bits of an entry)
//  AVAILABLE_CREDIT_WIDTH  25      width of available_credit field (lower bits)
//  RAM_DATA_WIDTH          40      FINAL_UP_LIMIT_WIDTH + AVAILABLE_CREDIT_WIDTH
//  RAM_MEM_SIZE            64      number of entries; need not be a power of two
//  INIT_VALUE              0       entry value written by the init sweep (RAM_DATA_WIDTH bits)
// PORTS (AW = $clog2(RAM_MEM_SIZE))
//  clk        in   1    clock, all logic on posedge
//  rst_n      in   1    asynchronous active-low reset
//  init_req   in   1    request a re-sweep of the whole table (honoured in IDLE only)
//  init_busy  out  1    1 while the sweep runs; all port requests ignored
//  rd_en      in   1    policer read request
//  rd_addr    in   AW   policer read address
//  rd_valid   out  1    rd_data valid (one cycle after an accepted rd_en)
//  rd_data    out  RDW  registered read data
//  wr_en      in   1    policer write (highest priority, never stalled)
//  wr_addr    in   AW   policer write address
//  wr_data    in   RDW  policer write data
//  cfg_wr_en  in   1    host config write request; hold until cfg_ack
//  cfg_addr   in   AW   config address
//  cfg_data   in   RDW  config data
//  cfg_ack    out  1    one-cycle pulse on the edge the config write is committed
// BEHAVIOUR
//  Reset (rst_n=0, async): state=INIT, sweep ptr=0, init_busy=1, rd_valid=0, rd_data=0, cfg_ack=0.
//   Memory contents are not reset by rst_n; the sweep rewrites them.
//  FSM INIT: each edge writes INIT_VALUE to mem[ptr]; ptr++. When ptr==RAM_MEM_SIZE-1 is written -> IDLE, init_busy=0.
//   Sweep takes exactly RAM_MEM_SIZE edges after rst_n rises.
//   rd_en/wr_en/cfg_wr_en ignored during the sweep: no write, rd_valid=0, cfg_ack=0.
//  FSM IDLE: init_req=1 -> INIT with ptr=0 on the next edge; requests on that same edge are still serviced.
//  Reset asserted mid-sweep or mid-traffic: immediate return to INIT; sweep restarts from 0 on release.
//  Read: accepted rd_en at edge N -> rd_valid=1, rd_data=entry at edge N, visible after edge N. rd_valid=0 otherwise.
//   rd_data holds its last value while rd_valid=0.
//  Forwarding (write-first): same-cycle read and commit to the same address -> rd_data = committed write data.
//  Write arbitration: one commit per edge.
//   wr_en beats cfg_wr_en; if both are high, only the policer write commits, cfg_ack=0, cfg waits.
//   cfg commits on the first edge with wr_en=0 in IDLE; cfg_ack=1 for that cycle only.
//   Host must drop cfg_wr_en, or present a new request, after ack.
//  Address guard: addr >= RAM_MEM_SIZE -> write dropped (cfg still acked); read gives rd_valid=1, rd_data=0.
//  Field layout: entry[RDW-1 -: FINAL_UP_LIMIT_WIDTH] = final_up_limit; entry[AVAILABLE_CREDIT_WIDTH-1:0] = available_credit.
//   No arithmetic is done in this block.
// TESTING
//  T1 Reset 3 cycles, release; count edges -> init_busy=1 for exactly 64 edges; then read every address -> all 0, rd_valid one cycle after each rd_en.
//  T2 Same cycle wr_en, wr_addr=5, wr_data=40'h12345_6789A; rd_en, rd_addr=5 -> next cycle rd_data=40'h12345_6789A. Later read of 5 returns the same value.
//  T3 Same cycle cfg_wr_en (addr 7, data 'hAA) and wr_en (addr 9, data 'hBB) -> mem[9]='hBB, cfg_ack=0. Next cycle, wr_en=0 -> cfg_ack=1, mem[7]='hAA.
//  T4 Write mem[3]='h55, then assert init_req -> init_busy for 64 edges, rd/wr ignored throughout; afterwards mem[3]=INIT_VALUE.
//  T5 Drop rst_n at sweep ptr=20 -> init_busy stays 1, rd_valid=0; after release the sweep restarts at 0 and completes in 64 edges.
//  T6 RAM_MEM_SIZE=48: write addr 50 then read addr 50 -> cfg_ack=1, no entry changed, rd_valid=1, rd_data=0. Address 47 is fully functional.

Source files
------------

// File: rtl/credit_table_ram_if.sv
// Purpose : groups the host/policer side of the credit table into one bundle.
// Latency : n/a (wires only).
// Backpressure: the config write is held by the master until cfg_ack; the policer ports are never stalled.
//
// Signals (slave = the table, master = the policer/host side):
//   init_req / init_busy              re-sweep request and sweep-in-progress flag
//   rd_en, rd_addr / rd_valid, rd_data registered policer read
//   wr_en, wr_addr, wr_data           policer write, highest priority
//   cfg_wr_en, cfg_addr, cfg_data / cfg_ack  host config write with commit pulse
interface credit_table_ram_if #(
    parameter int AW  = 6,
    parameter int RDW = 40
);
    logic           init_req;
    logic           init_busy;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic           rd_valid;
    logic [RDW-1:0] rd_data;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [RDW-1:0] wr_data;
    logic           cfg_wr_en;
    logic [AW-1:0]  cfg_addr;
    logic [RDW-1:0] cfg_data;
    logic           cfg_ack;

    modport master (
        output init_req, rd_en, rd_addr, wr_en, wr_addr, wr_data,
               cfg_wr_en, cfg_addr, cfg_data,
        input  init_busy, rd_valid, rd_data, cfg_ack
    );

    modport slave (
        input  init_req, rd_en, rd_addr, wr_en, wr_addr, wr_data,
               cfg_wr_en, cfg_addr, cfg_data,
        output init_busy, rd_valid, rd_data, cfg_ack
    );
endinterface

// File: rtl/credit_table_ram.sv
// Purpose : per-VC credit table {final_up_limit, available_credit} with policer read/write and host config write.
// Latency : read data registered, valid one cycle after an accepted rd_en; writes commit on the request edge.
// Backpressure: policer write never stalls; config write waits for a free write slot and is acked with a pulse.
//
// Ports:
//   clk    : clock, everything on posedge
//   rst_n  : asynchronous active-low reset; restarts the init sweep (memory itself is not reset)
//   bus    : credit_table_ram_if.slave -- read, policer write, config write and init handshake
module credit_table_ram #(
    parameter int FINAL_UP_LIMIT_WIDTH   = 15,
    parameter int AVAILABLE_CREDIT_WIDTH = 25,
    parameter int RAM_DATA_WIDTH         = FINAL_UP_LIMIT_WIDTH + AVAILABLE_CREDIT_WIDTH,
    parameter int RAM_MEM_SIZE           = 64,
    parameter logic [RAM_DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    credit_table_ram_if.slave bus
);

    localparam int AW = (RAM_MEM_SIZE > 1) ? $clog2(RAM_MEM_SIZE) : 1;
    // One extra bit so the range compare works when the size is a power of two.
    localparam logic [AW:0]   MEM_SIZE = (AW+1)'(RAM_MEM_SIZE);
    localparam logic [AW-1:0] LAST_PTR = AW'(RAM_MEM_SIZE - 1);

    // Entry layout: final_up_limit in the upper bits, available_credit in the lower bits.
    // The table only stores entries; the policer does all arithmetic on them.
    typedef struct packed {
        logic [FINAL_UP_LIMIT_WIDTH-1:0]   final_up_limit;
        logic [AVAILABLE_CREDIT_WIDTH-1:0] available_credit;
    } entry_t;

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_e;

    state_e                    state_q, state_d;
    logic [AW-1:0]             ptr_q, ptr_d;
    logic                      init_busy_q, init_busy_d;
    logic                      rd_valid_q, rd_valid_d;
    logic [RAM_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                      cfg_ack_q, cfg_ack_d;

    entry_t                    mem_q [RAM_MEM_SIZE];

    // Single write port shared by the sweep, the policer and the host.
    logic                      mem_we;
    logic [AW-1:0]             mem_waddr;
    entry_t                    mem_wdata;

    logic                      wr_in_range;
    logic                      cfg_in_range;
    logic                      rd_in_range;

    assign wr_in_range  = ({1'b0, bus.wr_addr}  < MEM_SIZE);
    assign cfg_in_range = ({1'b0, bus.cfg_addr} < MEM_SIZE);
    assign rd_in_range  = ({1'b0, bus.rd_addr}  < MEM_SIZE);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        init_busy_d = init_busy_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        cfg_ack_d   = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = ptr_q;
        mem_wdata   = INIT_VALUE;

        case (state_q)
            ST_INIT: begin
                // Sweep owns the write port; all requests are ignored.
                mem_we = 1'b1;
                if (ptr_q == LAST_PTR) begin
                    state_d     = ST_IDLE;
                    init_busy_d = 1'b0;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end

            default: begin
                // Policer write wins; host write takes the slot only when the policer is quiet.
                // Out-of-range writes still consume the slot (and ack the host) but never touch memory.
                if (bus.wr_en) begin
                    mem_we    = wr_in_range;
                    mem_waddr = bus.wr_addr;
                    mem_wdata = bus.wr_data;
                end else if (bus.cfg_wr_en) begin
                    mem_we    = cfg_in_range;
                    mem_waddr = bus.cfg_addr;
                    mem_wdata = bus.cfg_data;
                    cfg_ack_d = 1'b1;
                end

                if (bus.rd_en) begin
                    rd_valid_d = 1'b1;
                    if (!rd_in_range) begin
                        rd_data_d = '0;
                    end else if (mem_we && (mem_waddr == bus.rd_addr)) begin
                        // Write-first: the policer must see the value committed on this edge.
                        rd_data_d = mem_wdata;
                    end else begin
                        rd_data_d = mem_q[bus.rd_addr];
                    end
                end

                // Requests on the init_req edge are still serviced above.
                if (bus.init_req) begin
                    state_d     = ST_INIT;
                    ptr_d       = '0;
                    init_busy_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            ptr_q       <= '0;
            init_busy_q <= 1'b1;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            cfg_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            init_busy_q <= init_busy_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            cfg_ack_q   <= cfg_ack_d;
        end
    end

    // Storage array: no reset, contents are established by the sweep.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.init_busy = init_busy_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.cfg_ack   = cfg_ack_q;

endmodule

// File: tb/tb_credit_table_ram.sv
// Purpose : self-checking bench for credit_table_ram; a 64-entry and a 48-entry table run on shared stimulus.
// Latency : expected read data is queued when rd_en is driven and compared when rd_valid appears.
// Backpressure: the host model holds cfg_wr_en until the model predicts cfg_ack.
module tb_credit_table_ram;

    localparam int AW  = 6;
    localparam int RDW = 40;
    localparam logic [RDW-1:0] INIT48 = 40'hA55A0000C3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           init_req = 1'b0;
    logic           rd_en = 1'b0;
    logic [AW-1:0]  rd_addr = '0;
    logic           wr_en = 1'b0;
    logic [AW-1:0]  wr_addr = '0;
    logic [RDW-1:0] wr_data = '0;
    logic           cfg_wr_en = 1'b0;
    logic [AW-1:0]  cfg_addr = '0;
    logic [RDW-1:0] cfg_data = '0;

    always #5 clk = ~clk;

    credit_table_ram_if #(.AW(AW), .RDW(RDW)) if64 ();
    credit_table_ram_if #(.AW(AW), .RDW(RDW)) if48 ();

    assign if64.init_req  = init_req;   assign if48.init_req  = init_req;
    assign if64.rd_en     = rd_en;      assign if48.rd_en     = rd_en;
    assign if64.rd_addr   = rd_addr;    assign if48.rd_addr   = rd_addr;
    assign if64.wr_en     = wr_en;      assign if48.wr_en     = wr_en;
    assign if64.wr_addr   = wr_addr;    assign if48.wr_addr   = wr_addr;
    assign if64.wr_data   = wr_data;    assign if48.wr_data   = wr_data;
    assign if64.cfg_wr_en = cfg_wr_en;  assign if48.cfg_wr_en = cfg_wr_en;
    assign if64.cfg_addr  = cfg_addr;   assign if48.cfg_addr  = cfg_addr;
    assign if64.cfg_data  = cfg_data;   assign if48.cfg_data  = cfg_data;

    credit_table_ram #(.RAM_MEM_SIZE(64)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if64)
    );

    credit_table_ram #(.RAM_MEM_SIZE(48), .INIT_VALUE(INIT48)) dut48 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if48)
    );

    // Reference model, index 0 = 64 entries, index 1 = 48 entries.
    int             m_size [2];
    logic [RDW-1:0] m_init [2];
    logic [RDW-1:0] m_mem  [2][64];
    logic           m_busy [2];
    int             m_ptr  [2];
    logic           e_vld  [2];
    logic           e_ack  [2];
    logic [RDW-1:0] e_last [2];
    logic [RDW-1:0] sb_q0 [$];
    logic [RDW-1:0] sb_q1 [$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        m_busy[k] = 1'b1;
        m_ptr[k]  = 0;
        e_vld[k]  = 1'b0;
        e_ack[k]  = 1'b0;
        e_last[k] = '0;
    endtask

    // Predict the effect of the coming edge on table k from the current inputs.
    task automatic model_edge(input int k);
        logic           we;
        int             wa;
        logic [RDW-1:0] wd;
        logic [RDW-1:0] rdv;
        e_vld[k] = 1'b0;
        e_ack[k] = 1'b0;
        if (!rst_n) begin
            model_reset(k);
            return;
        end
        if (m_busy[k]) begin
            m_mem[k][m_ptr[k]] = m_init[k];
            if (m_ptr[k] == m_size[k] - 1) m_busy[k] = 1'b0;
            else m_ptr[k]++;
            return;
        end
        we = 1'b0; wa = 0; wd = '0;
        if (wr_en) begin
            we = (int'(wr_addr) < m_size[k]); wa = int'(wr_addr); wd = wr_data;
        end else if (cfg_wr_en) begin
            e_ack[k] = 1'b1;
            we = (int'(cfg_addr) < m_size[k]); wa = int'(cfg_addr); wd = cfg_data;
        end
        if (rd_en) begin
            e_vld[k] = 1'b1;
            if (int'(rd_addr) >= m_size[k]) rdv = '0;
            else if (we && wa == int'(rd_addr)) rdv = wd;
            else rdv = m_mem[k][int'(rd_addr)];
            if (k == 0) sb_q0.push_back(rdv);
            else sb_q1.push_back(rdv);
        end
        if (we) m_mem[k][wa] = wd;
        if (init_req) begin
            m_busy[k] = 1'b1;
            m_ptr[k]  = 0;
        end
    endtask

    task automatic compare(input int k);
        logic           busy, vld, ack;
        logic [RDW-1:0] dat, exp;
        string          nm;
        nm = $sformatf("m%0d", m_size[k]);
        if (k == 0) begin
            busy = if64.init_busy; vld = if64.rd_valid; ack = if64.cfg_ack; dat = if64.rd_data;
        end else begin
            busy = if48.init_busy; vld = if48.rd_valid; ack = if48.cfg_ack; dat = if48.rd_data;
        end
        check({nm, "_init_busy"}, busy, m_busy[k]);
        check({nm, "_rd_valid"}, vld, e_vld[k]);
        check({nm, "_cfg_ack"}, ack, e_ack[k]);
        if (vld && (k == 0 ? sb_q0.size() : sb_q1.size()) > 0) begin
            exp = (k == 0) ? sb_q0.pop_front() : sb_q1.pop_front();
            check({nm, "_rd_data"}, dat, exp);
            e_last[k] = exp;
        end else if (!vld) begin
            check({nm, "_rd_hold"}, dat, e_last[k]);
            if (k == 0) sb_q0.delete();
            else sb_q1.delete();
        end
    endtask

    task automatic step();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        @(negedge clk);
        compare(0);
        compare(1);
    endtask

    task automatic idle_inputs();
        init_req = 1'b0; rd_en = 1'b0; wr_en = 1'b0; cfg_wr_en = 1'b0;
    endtask

    // Asynchronous reset: state must change without waiting for a clock edge.
    task automatic assert_reset();
        rst_n = 1'b0;
        model_reset(0);
        model_reset(1);
        sb_q0.delete();
        sb_q1.delete();
        #1;
        check("arst_busy64", if64.init_busy, 1'b1);
        check("arst_busy48", if48.init_busy, 1'b1);
        check("arst_vld64", if64.rd_valid, 1'b0);
        check("arst_vld48", if48.rd_valid, 1'b0);
        check("arst_ack64", if64.cfg_ack, 1'b0);
        check("arst_dat48", if48.rd_data, '0);
    endtask

    // Count edges with init_busy high until both sweeps end; optional traffic must be ignored.
    task automatic sweep_count(input string tag, input bit traffic);
        int c0 = 0;
        int c1 = 0;
        for (int i = 0; i < 200; i++) begin
            if (!if64.init_busy && !if48.init_busy) break;
            if (if64.init_busy) c0++;
            if (if48.init_busy) c1++;
            if (traffic && i < 40) begin
                rd_en = 1'b1; rd_addr = 6'd3;
                wr_en = 1'b1; wr_addr = 6'd3; wr_data = 40'hFF_FFFF_FFFF;
            end else begin
                idle_inputs();
            end
            step();
        end
        idle_inputs();
        check({tag, "_len64"}, c0, 64);
        check({tag, "_len48"}, c1, 48);
    endtask

    task automatic read_all();
        for (int a = 0; a < 64; a++) begin
            rd_en = 1'b1; rd_addr = 6'(a);
            step();
        end
        rd_en = 1'b0;
    endtask

    initial begin
        m_size[0] = 64; m_size[1] = 48;
        m_init[0] = '0; m_init[1] = INIT48;
        model_reset(0);
        model_reset(1);

        // T1: reset, sweep length, every entry initialised
        #2;
        assert_reset();
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b1;
        sweep_count("t1_sweep", 1'b0);
        read_all();

        // T2: same-cycle write and read of one address returns the new value
        wr_en = 1'b1; wr_addr = 6'd5; wr_data = 40'h123456789A;
        rd_en = 1'b1; rd_addr = 6'd5;
        step();
        idle_inputs();
        step();
        rd_en = 1'b1; rd_addr = 6'd5;
        step();
        idle_inputs();

        // T3: policer write beats config write; config commits on the next free slot
        cfg_wr_en = 1'b1; cfg_addr = 6'd7; cfg_data = 40'hAA;
        wr_en = 1'b1; wr_addr = 6'd9; wr_data = 40'hBB;
        step();
        wr_en = 1'b0;
        step();
        cfg_wr_en = 1'b0;
        rd_en = 1'b1; rd_addr = 6'd9; step();
        rd_addr = 6'd7; step();
        idle_inputs();

        // Random mixed traffic, host holding cfg requests until acked
        for (int i = 0; i < 300; i++) begin
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = 6'($urandom_range(0, 63));
            wr_data = RDW'({$urandom(), $urandom()});
            if (!cfg_wr_en && $urandom_range(0, 3) == 0) begin
                cfg_wr_en = 1'b1;
                cfg_addr  = 6'($urandom_range(0, 63));
                cfg_data  = RDW'({$urandom(), $urandom()});
            end
            rd_en = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 3))
                0:       rd_addr = wr_addr;
                1:       rd_addr = cfg_addr;
                default: rd_addr = 6'($urandom_range(0, 63));
            endcase
            step();
            if (e_ack[0]) cfg_wr_en = 1'b0;
        end
        idle_inputs();
        step();

        // T4: init_req re-sweep ignores traffic and restores INIT_VALUE
        wr_en = 1'b1; wr_addr = 6'd3; wr_data = 40'h55;
        step();
        wr_en = 1'b0;
        init_req = 1'b1; rd_en = 1'b1; rd_addr = 6'd3;
        step();
        idle_inputs();
        sweep_count("t4_sweep", 1'b1);
        read_all();

        // T5: reset in the middle of a sweep restarts it from zero
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        for (int i = 0; i < 100 && m_ptr[0] != 20; i++) step();
        assert_reset();
        rd_en = 1'b1; rd_addr = 6'd1;
        step();
        step();
        idle_inputs();
        rst_n = 1'b1;
        sweep_count("t5_sweep", 1'b0);

        // T6: out-of-range addresses on the 48-entry table; last entry fully usable
        cfg_wr_en = 1'b1; cfg_addr = 6'd50; cfg_data = 40'hDEAD;
        step();
        cfg_wr_en = 1'b0;
        wr_en = 1'b1; wr_addr = 6'd50; wr_data = 40'hBEEF;
        step();
        wr_en = 1'b0;
        rd_en = 1'b1; rd_addr = 6'd50;
        step();
        idle_inputs();
        read_all();
        wr_en = 1'b1; wr_addr = 6'd47; wr_data = 40'h7F_0000_1234;
        rd_en = 1'b1; rd_addr = 6'd47;
        step();
        wr_en = 1'b0;
        cfg_wr_en = 1'b1; cfg_addr = 6'd47; cfg_data = 40'h01_2345_6789;
        step();
        cfg_wr_en = 1'b0;
        step();
        idle_inputs();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
